// File: rtl/tdc_phase_sampler_if.sv
// Bundle between the ring-oscillator sampler and its consumer: enable,
// raw inverter taps, and the decoded phase / diff / window results.
interface tdc_phase_sampler_if #(
  parameter int N_INV = 16,
  parameter int ACC_W = 12
);
  localparam int PH_W = $clog2(2 * N_INV);

  logic             en;
  logic [N_INV-1:0] inv_out;
  logic [PH_W-1:0]  phase;
  logic             phase_vld;
  logic [PH_W-1:0]  phase_diff;
  logic             diff_vld;
  logic             bubble_err;
  logic [ACC_W-1:0] win_sum;
  logic             win_done;

  modport master (
    output en, inv_out,
    input  phase, phase_vld, phase_diff, diff_vld, bubble_err, win_sum, win_done
  );

  modport slave (
    input  en, inv_out,
    output phase, phase_vld, phase_diff, diff_vld, bubble_err, win_sum, win_done
  );
endinterface

// File: rtl/tdc_phase_sampler.sv
// TDC fine-phase stage: synchronise ring taps, normalise to thermometer code,
// encode to a 5-bit phase, and accumulate wrap-around phase steps per window.
module tdc_phase_sampler #(
  parameter int N_INV    = 16,
  parameter int WIN_LOG2 = 4,
  parameter int ACC_W    = 12
) (
  input  logic              clk,
  input  logic              rst,
  tdc_phase_sampler_if.slave bus
);
  localparam int PH_W = $clog2(2 * N_INV);
  localparam logic [N_INV-1:0] POL_MASK = {(N_INV/2){2'b10}};
  // The IDLE edge that sees en counts as the first of the three fill cycles.
  localparam logic [1:0] FILL_LAST = 2'd1;

  typedef enum logic [1:0] {IDLE, FILL, RUN} state_e;

  function automatic logic [PH_W-1:0] popcnt(input logic [N_INV-1:0] v);
    logic [PH_W-1:0] c;
    c = '0;
    for (int i = 0; i < N_INV; i++) c = c + PH_W'(v[i]);
    return c;
  endfunction

  function automatic logic [PH_W-1:0] encode(input logic [N_INV-1:0] n);
    if (n[N_INV-1]) return PH_W'(N_INV) + popcnt(~n);
    else            return popcnt(n);
  endfunction

  function automatic logic is_bubble(input logic [N_INV-1:0] n);
    logic [N_INV-2:0] edges;
    edges = n[N_INV-1:1] ^ n[N_INV-2:0];
    return popcnt({1'b0, edges}) > PH_W'(1);
  endfunction

  state_e           state_q, state_d;
  logic [N_INV-1:0] s1_q, s2_q;
  logic [1:0]       fill_q, fill_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic [PH_W-1:0]  diff_q, diff_d;
  logic             bubble_q, bubble_d;
  logic             pvld_q, pvld_d;
  logic             dvld_q, dvld_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [WIN_LOG2-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] wsum_q, wsum_d;
  logic             wdone_q, wdone_d;

  logic [N_INV-1:0] norm;
  logic [PH_W-1:0]  p_enc;
  logic             p_bub;
  logic [ACC_W-1:0] diff_ext;

  assign norm     = s2_q ^ POL_MASK;
  assign p_enc    = encode(norm);
  assign p_bub    = is_bubble(norm);
  assign diff_ext = {{(ACC_W-PH_W){1'b0}}, diff_q};

  always_comb begin
    state_d  = state_q;
    fill_d   = fill_q;
    phase_d  = phase_q;
    diff_d   = diff_q;
    bubble_d = bubble_q;
    pvld_d   = 1'b0;
    dvld_d   = 1'b0;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    wsum_d   = wsum_q;
    wdone_d  = 1'b0;

    if (bus.en) begin
      phase_d  = p_enc;
      diff_d   = p_enc - phase_q;
      bubble_d = p_bub;
    end

    unique case (state_q)
      IDLE: begin
        if (bus.en) begin
          state_d = FILL;
          fill_d  = '0;
        end
      end
      FILL: begin
        if (!bus.en) begin
          state_d = IDLE;
        end else if (fill_q == FILL_LAST) begin
          state_d = RUN;
          pvld_d  = 1'b1;
        end else begin
          fill_d = fill_q + 2'd1;
        end
      end
      RUN: begin
        if (!bus.en) begin
          state_d = IDLE;
        end else begin
          pvld_d = 1'b1;
          // The first RUN phase has no predecessor, so diffs start one cycle later.
          dvld_d = 1'b1;
          if (dvld_q) begin
            if (cnt_q == {WIN_LOG2{1'b1}}) begin
              wsum_d  = acc_q + diff_ext;
              wdone_d = 1'b1;
              acc_d   = '0;
              cnt_d   = '0;
            end else begin
              acc_d = acc_q + diff_ext;
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (!bus.en) begin
      acc_d  = '0;
      cnt_d  = '0;
      fill_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      s1_q     <= '0;
      s2_q     <= '0;
      fill_q   <= '0;
      phase_q  <= '0;
      diff_q   <= '0;
      bubble_q <= 1'b0;
      pvld_q   <= 1'b0;
      dvld_q   <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
      wsum_q   <= '0;
      wdone_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      s1_q     <= bus.inv_out;
      s2_q     <= s1_q;
      fill_q   <= fill_d;
      phase_q  <= phase_d;
      diff_q   <= diff_d;
      bubble_q <= bubble_d;
      pvld_q   <= pvld_d;
      dvld_q   <= dvld_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      wsum_q   <= wsum_d;
      wdone_q  <= wdone_d;
    end
  end

  assign bus.phase      = phase_q;
  assign bus.phase_vld  = pvld_q;
  assign bus.phase_diff = diff_q;
  assign bus.diff_vld   = dvld_q;
  assign bus.bubble_err = bubble_q;
  assign bus.win_sum    = wsum_q;
  assign bus.win_done   = wdone_q;
endmodule

// File: tb/tb_tdc_phase_sampler.sv
// Directed bench for tdc_phase_sampler: fill timing, decode, wrap diffs,
// bubble flag, window sums, enable drop and reset priority.
module tb_tdc_phase_sampler;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tdc_phase_sampler_if #(.N_INV(16), .ACC_W(12)) bus ();

  tdc_phase_sampler #(.N_INV(16), .WIN_LOG2(4), .ACC_W(12)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors = 0;
  int miscompares = 0;
  int pulses;

  logic [15:0] sweep_n [6];
  logic [15:0] sweep_p [6];
  logic [15:0] step_n  [4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive the normalised pattern n; odd taps of the ring are inverted.
  task automatic drive_n(input logic [15:0] n);
    bus.inv_out = n ^ 16'hAAAA;
  endtask

  initial begin
    sweep_n = '{16'h0001, 16'h00FF, 16'hFFFF, 16'hFFFE, 16'hFF00, 16'h8000};
    sweep_p = '{16'd1, 16'd8, 16'd16, 16'd17, 16'd24, 16'd31};
    step_n  = '{16'h0000, 16'h00FF, 16'hFFFF, 16'hFF00};

    rst = 1'b1;
    bus.en = 1'b0;
    drive_n(16'h0000);
    tick();
    tick();
    chk("rst_phase",  16'(bus.phase),      16'd0);
    chk("rst_pvld",   16'(bus.phase_vld),  16'd0);
    chk("rst_dvld",   16'(bus.diff_vld),   16'd0);
    chk("rst_bubble", 16'(bus.bubble_err), 16'd0);
    chk("rst_wsum",   16'(bus.win_sum),    16'd0);
    chk("rst_wdone",  16'(bus.win_done),   16'd0);

    // Static n=0: fill, then a window of zero diffs
    rst = 1'b0;
    tick();
    bus.en = 1'b1;
    tick();
    chk("fill1_pvld", 16'(bus.phase_vld), 16'd0);
    tick();
    chk("fill2_pvld", 16'(bus.phase_vld), 16'd0);
    tick();
    chk("run_pvld",   16'(bus.phase_vld),  16'd1);
    chk("run_phase",  16'(bus.phase),      16'd0);
    chk("run_bubble", 16'(bus.bubble_err), 16'd0);
    chk("run1_dvld",  16'(bus.diff_vld),   16'd0);
    tick();
    chk("run2_dvld", 16'(bus.diff_vld),   16'd1);
    chk("run2_diff", 16'(bus.phase_diff), 16'd0);
    repeat (15) tick();
    chk("static_predone", 16'(bus.win_done), 16'd0);
    tick();
    chk("static_done", 16'(bus.win_done), 16'd1);
    chk("static_wsum", 16'(bus.win_sum),  16'd0);
    tick();
    chk("static_postdone", 16'(bus.win_done), 16'd0);

    // Decode sweep
    for (int k = 0; k < 6; k++) begin
      drive_n(sweep_n[k]);
      repeat (4) tick();
      chk("sweep_phase",  16'(bus.phase),      sweep_p[k]);
      chk("sweep_bubble", 16'(bus.bubble_err), 16'd0);
    end

    // Bubble pattern: popcount still reported
    drive_n(16'h00F5);
    repeat (4) tick();
    chk("bubble_flag",  16'(bus.bubble_err), 16'd1);
    chk("bubble_phase", 16'(bus.phase),      16'd6);

    // Wrap: 28 -> 4 -> 12 on consecutive cycles
    drive_n(16'hF000);
    repeat (4) tick();
    chk("wrap_p28", 16'(bus.phase), 16'd28);
    drive_n(16'h000F);
    tick();
    drive_n(16'h0FFF);
    tick();
    tick();
    chk("wrap_p4",  16'(bus.phase),      16'd4);
    chk("wrap_d1",  16'(bus.phase_diff), 16'd8);
    tick();
    chk("wrap_p12", 16'(bus.phase),      16'd12);
    chk("wrap_d2",  16'(bus.phase_diff), 16'd8);

    // Realign via en drop, then step-8 phases through a full window and 10 more diffs
    bus.en = 1'b0;
    tick();
    chk("drop0_pvld", 16'(bus.phase_vld), 16'd0);
    bus.en = 1'b1;
    drive_n(step_n[0]);
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (i == 2)  chk("step_fill_pvld", 16'(bus.phase_vld), 16'd0);
      if (i == 3)  chk("step_pvld",      16'(bus.phase_vld), 16'd1);
      if (i == 3)  chk("step_phase0",    16'(bus.phase),     16'd0);
      if (i == 4)  chk("step_diff",      16'(bus.phase_diff), 16'd8);
      if (i == 19) chk("step_predone",   16'(bus.win_done),  16'd0);
      if (i == 20) chk("step_done",      16'(bus.win_done),  16'd1);
      if (i == 20) chk("step_wsum",      16'(bus.win_sum),   16'd128);
      if (i == 21) chk("step_postdone",  16'(bus.win_done),  16'd0);
      if (i < 30) drive_n(step_n[i % 4]);
    end

    // en drop after 10 diffs of the new window
    bus.en = 1'b0;
    drive_n(16'h0001);
    tick();
    chk("drop_pvld",  16'(bus.phase_vld), 16'd0);
    chk("drop_dvld",  16'(bus.diff_vld),  16'd0);
    chk("drop_wdone", 16'(bus.win_done),  16'd0);
    chk("drop_phase", 16'(bus.phase),     16'd24);
    chk("drop_wsum",  16'(bus.win_sum),   16'd128);

    bus.en = 1'b1;
    pulses = 0;
    for (int j = 1; j <= 20; j++) begin
      tick();
      if (j < 20 && bus.win_done) pulses++;
      if (j == 2) chk("refill_pvld",  16'(bus.phase_vld),  16'd0);
      if (j == 3) chk("rerun_pvld",   16'(bus.phase_vld),  16'd1);
      if (j == 3) chk("rerun_phase",  16'(bus.phase),      16'd1);
      if (j == 3) chk("rerun_dvld",   16'(bus.diff_vld),   16'd0);
      if (j == 4) chk("rerun_diff",   16'(bus.phase_diff), 16'd0);
    end
    chk("fresh_early_done", 16'(pulses),       16'd0);
    chk("fresh_done",       16'(bus.win_done), 16'd1);
    chk("fresh_wsum",       16'(bus.win_sum),  16'd0);

    // Reset wins over en during RUN
    rst = 1'b1;
    tick();
    chk("rp_phase", 16'(bus.phase),      16'd0);
    chk("rp_pvld",  16'(bus.phase_vld),  16'd0);
    chk("rp_dvld",  16'(bus.diff_vld),   16'd0);
    chk("rp_wdone", 16'(bus.win_done),   16'd0);
    chk("rp_wsum",  16'(bus.win_sum),    16'd0);
    rst = 1'b0;
    tick();
    chk("rp_fill1", 16'(bus.phase_vld), 16'd0);
    tick();
    chk("rp_fill2", 16'(bus.phase_vld), 16'd0);
    tick();
    chk("rp_pvld_back", 16'(bus.phase_vld), 16'd1);
    chk("rp_phase_back", 16'(bus.phase),    16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/tdc_phase_sampler.md
Name: tdc_phase_sampler

Overview:
- Reference-clock-domain capture and decode stage directly downstream of the 16-inverter ring oscillator in the TDC.
- Samples the 16 inverter outputs, normalises the alternating-polarity pattern into a thermometer code, and encodes it to a 5-bit fine phase (0..31).
- Emits per-cycle phase differences modulo 32 and a windowed accumulation of them, used for DCO period/frequency estimation.

Parameters:
- N_INV, 16, inverter stages sampled. Fixed at 16; the fine phase is log2(2*N_INV) = 5 bits.
- WIN_LOG2, 4, accumulation window is 2**WIN_LOG2 valid diffs.
- ACC_W, 12, width of the window accumulator. Must be ≥ 5+WIN_LOG2.

Ports:
- clk  in  1  reference clock.
- rst  in  1  synchronous reset, active-high.
- en  in  1  enables sampling/decoding. Deassertion returns the pipeline to IDLE.
- inv_out  in  16  raw ring inverter outputs, asynchronous to clk.
- phase  out  5  decoded fine phase.
- phase_vld  out  1  phase is valid this cycle.
- phase_diff  out  5  (phase - previous phase) mod 32.
- diff_vld  out  1  phase_diff valid.
- bubble_err  out  1  sampled normalised code was not a clean thermometer code.
- win_sum  out  ACC_W  sum of the last window of phase_diff values.
- win_done  out  1  one-cycle pulse when win_sum updates.

Behaviour:
- Reset: one clock, synchronous active-high rst. All registers clear, FSM to IDLE, all outputs 0. rst has priority over en.
- S0/S1 capture: inv_out goes through a 2-flop synchroniser (s1, s2), bitwise.
- Normalise (combinational on s2): n = s2 ^ 16'hAAAA, so odd bits are inverted.
- Encode: if n[15]==0, p = popcount(n); else p = 16 + popcount(~n); result taken mod 32.
  - Examples: n=0x0000 -> 0; 0x0001 -> 1; 0xFFFF -> 16; 0xFFFE -> 17; 0x8000 -> 31.
- Bubble check: bubble_err=1 when n has more than one 0/1 transition between adjacent bits (bit0..bit15).
  - p is still produced by popcount; no suppression.
  - bubble_err is registered alongside phase.
- Stage E register: phase <= p and bubble_err are registered together.
- Latency: inv_out change to phase output is 3 clk cycles (2 synchroniser + 1 encode).
- Diff: phase_diff <= (p - phase) mod 32, i.e. 5-bit unsigned wrap subtraction against the previous registered phase.
- FSM states: IDLE, FILL, RUN.
  - IDLE: all vld outputs 0. On en=1 -> FILL, fill counter cleared.
  - FILL: counts 3 cycles while the pipeline fills. phase_vld asserts on the cycle the 3rd count completes; next state RUN.
  - RUN: phase_vld=1 every cycle. diff_vld=1 from the 2nd RUN cycle onward; the first RUN phase has no predecessor.
  - Any state: en=0 -> IDLE on the next edge. phase_vld, diff_vld and win_done go to 0 on that same edge. The accumulator and window count clear; phase/win_sum hold their last values.
- Window accumulator, in RUN with diff_vld=1:
  - acc += zero-extended phase_diff; cnt increments.
  - When cnt reaches 2**WIN_LOG2-1, on the same edge: win_sum <= acc + phase_diff, win_done=1 for one cycle, acc <= 0, cnt <= 0. No lost sample.
  - acc never overflows by construction (ACC_W ≥ 5+WIN_LOG2).
- Re-enable after IDLE restarts FILL. No stale diff is generated against the pre-IDLE phase.
- rst mid-window discards the partial sum; win_done is not pulsed.

Test Plan:
- Static inputs: rst, then en=1, inv_out=16'hAAAA (n=0) -> phase_vld rises 3 cycles after en; phase=0, phase_diff=0, bubble_err=0. After 16 diffs: win_sum=0, win_done pulses once.
- Decode sweep: drive n patterns 0x0001, 0x00FF, 0xFFFF, 0xFFFE, 0xFF00, 0x8000 (inv_out = n^0xAAAA), each held ≥4 cycles -> phase = 1, 8, 16, 17, 24, 31, bubble_err=0.
- Wrap: phase sequence 28, 4, 12 on consecutive cycles -> phase_diff = 8, 8. Constant step 8 over a 16-diff window -> win_sum=128.
- Bubble: n=0x00F5 -> bubble_err=1, phase = popcount = 6.
- en drop: deassert en mid-window after 10 diffs, re-enable -> vld outputs 0 on the next edge. FILL is repeated (3 cycles). The next win_done occurs only after 16 fresh diffs, with no carried sum.
- Reset priority: rst=1 and en=1 together during RUN -> next cycle all outputs 0 and FSM in IDLE. After rst release with en held, phase_vld returns 3 cycles later.
